// File: rtl/osc_bank_if.sv
// Sample-tick, configuration and mixed-output bundle for osc_bank.
// master drives ticks and config writes; slave is the oscillator bank.
interface osc_bank_if #(
  parameter int BITDEPTH = 14,
  parameter int VB       = 2
);
  logic                sample_tick;
  logic                cfg_we;
  logic [VB-1:0]       cfg_voice;
  logic [1:0]          cfg_addr;
  logic [15:0]         cfg_wdata;
  logic [BITDEPTH-1:0] out;
  logic                out_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_addr, cfg_wdata,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_addr, cfg_wdata,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one voice per cycle, mixed into one sample per sweep.
// Optional hard sync of voice v to voice v-1 wrap: define OSC_HARD_SYNC_EN.
module osc_bank #(
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 8,
  parameter int VOICES      = 4
) (
  input  logic      clk,
  input  logic      rst,
  osc_bank_if.slave bus
);
  localparam int ACCW  = BITDEPTH + BITFRACTION;
  localparam int ACCW1 = ACCW + 1;
  localparam int VB    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SH    = $clog2(VOICES);
  localparam int SUMW  = BITDEPTH + VB;
  localparam int MIXW  = BITDEPTH + 2;
  localparam logic [BITDEPTH-1:0] MIDPOINT = BITDEPTH'((1 << (BITDEPTH - 1)) - 1);
  localparam logic [MIXW-1:0]     N3_BIAS  = MIXW'(1 << (BITDEPTH - 3));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q;
  logic [VB-1:0]       idx_q;
  logic [SUMW-1:0]     sum_q;
  logic [BITDEPTH-1:0] out_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                overrun_q;

  logic [ACCW-1:0] acc_q [VOICES];
  logic            sq_q  [VOICES];
  logic [15:0]     inc_q [VOICES];
  logic [3:0]      sel_q [VOICES];
  logic [7:0]      pw_q  [VOICES];
`ifdef OSC_HARD_SYNC_EN
  logic              sync_q [VOICES];
  logic [VOICES-1:0] wrap_q;
  logic              carry;
`endif

  logic [ACCW-1:0]     cur_acc, acc_sum, acc_d;
  logic                sync_hit, sq_d;
  logic [3:0]          sel_cur;
  logic [BITDEPTH-1:0] saw, tri_w, pulse, square, pw_thr, voice_out;
  logic [2:0]          n_sel;
  logic [MIXW-1:0]     mix;
  logic [SUMW-1:0]     sum_d;

  // NOTE: every signal below is assigned on every path, so no latches are inferred.
  always_comb begin
    cur_acc = acc_q[idx_q];
    sel_cur = sel_q[idx_q];
`ifdef OSC_HARD_SYNC_EN
    {carry, acc_sum} = ACCW1'(cur_acc) + ACCW1'(inc_q[idx_q]);
    sync_hit = (idx_q != '0) && sync_q[idx_q] && wrap_q[idx_q - VB'(1)];
`else
    acc_sum  = cur_acc + ACCW'(inc_q[idx_q]);
    sync_hit = 1'b0;
`endif
    acc_d  = sync_hit ? '0 : acc_sum;
    sq_d   = sq_q[idx_q] ^ (!sync_hit && !cur_acc[ACCW-1] && acc_d[ACCW-1]);
    saw    = acc_d[ACCW-1 -: BITDEPTH];
    tri_w  = acc_d[ACCW-1] ? ~acc_d[ACCW-2 -: BITDEPTH] : acc_d[ACCW-2 -: BITDEPTH];
    pw_thr = BITDEPTH'(pw_q[idx_q]) << (BITDEPTH - 8);
    pulse  = (saw < pw_thr) ? '1 : '0;
    square = {BITDEPTH{sq_d}};

    n_sel = 3'(sel_cur[0]) + 3'(sel_cur[1]) + 3'(sel_cur[2]) + 3'(sel_cur[3]);
    mix   = '0;
    if (sel_cur[0]) mix = mix + MIXW'(saw);
    if (sel_cur[1]) mix = mix + MIXW'(tri_w);
    if (sel_cur[2]) mix = mix + MIXW'(square);
    if (sel_cur[3]) mix = mix + MIXW'(pulse);

    // Scale so any number of selected waves stays within full range.
    case (n_sel)
      3'd0:    voice_out = MIDPOINT;
      3'd1:    voice_out = mix[BITDEPTH-1:0];
      3'd2:    voice_out = mix[BITDEPTH:1];
      3'd3:    voice_out = BITDEPTH'((mix >> 2) + N3_BIAS);
      default: voice_out = mix[BITDEPTH+1:2];
    endcase
    sum_d = sum_q + SUMW'(voice_out);
  end

  // Configuration registers: writable in any state, visible from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-voice register file is reset element by element since its reset values are architectural.
      for (int v = 0; v < VOICES; v++) begin
        inc_q[v] <= '0;
        sel_q[v] <= '0;
        pw_q[v]  <= 8'd16;
`ifdef OSC_HARD_SYNC_EN
        sync_q[v] <= 1'b0;
`endif
      end
    end else if (bus.cfg_we && (int'(bus.cfg_voice) < VOICES)) begin
      case (bus.cfg_addr)
        2'd0: inc_q[bus.cfg_voice] <= bus.cfg_wdata;
        2'd1: sel_q[bus.cfg_voice] <= bus.cfg_wdata[3:0];
        2'd2: pw_q[bus.cfg_voice]  <= bus.cfg_wdata[7:0];
`ifdef OSC_HARD_SYNC_EN
        default: sync_q[bus.cfg_voice] <= bus.cfg_wdata[0];
`else
        default: ;
`endif
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      out_q       <= MIDPOINT;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef OSC_HARD_SYNC_EN
      wrap_q      <= '0;
`endif
      for (int v = 0; v < VOICES; v++) begin
        acc_q[v] <= '0;
        sq_q[v]  <= 1'b0;
      end
    end else begin
      out_valid_q <= 1'b0;
      overrun_q   <= bus.sample_tick && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.sample_tick) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
`ifdef OSC_HARD_SYNC_EN
            wrap_q  <= '0;
`endif
          end
        end
        S_RUN: begin
          acc_q[idx_q] <= acc_d;
          sq_q[idx_q]  <= sq_d;
`ifdef OSC_HARD_SYNC_EN
          wrap_q[idx_q] <= carry && !sync_hit;
`endif
          sum_q <= sum_d;
          idx_q <= idx_q + VB'(1);
          if (idx_q == VB'(VOICES - 1)) begin
            state_q     <= S_DONE;
            out_q       <= BITDEPTH'(sum_d >> SH);
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_osc_bank.sv
// Self-checking bench for osc_bank: single-tick vector table plus multi-tick corner sequences.
`timescale 1ns/1ps
module tb_osc_bank;
  localparam int     BD     = 14;
  localparam int     VOICES = 4;
  localparam int     VB     = 2;
  localparam int     MID    = 8191;
  localparam int     FULL   = 16383;
  localparam longint ACC_MOD = 64'd1 << 22;
  localparam longint HALF    = 64'd1 << 21;
`ifdef OSC_HARD_SYNC_EN
  localparam int SYNC_EXP = 6143;
`else
  localparam int SYNC_EXP = 6144;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osc_bank_if #(.BITDEPTH(BD), .VB(VB)) bus ();
  osc_bank #(.BITDEPTH(BD), .BITFRACTION(8), .VOICES(VOICES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Behavioural reference of the voice state.
  longint m_acc [4];
  int     m_inc [4];
  int     m_sel [4];
  int     m_pw  [4];
  bit     m_sync[4];
  bit     m_sq  [4];

  typedef struct {
    logic [15:0] inc;
    logic [15:0] sel;
    logic [15:0] pw;
    int          exp;
  } vec_t;
  vec_t vecs[10];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_acc[v] = 0; m_inc[v] = 0; m_sel[v] = 0; m_pw[v] = 16; m_sync[v] = 0; m_sq[v] = 0;
    end
  endtask

  function automatic int model_sweep();
    int total = 0;
    bit wr[4];
    for (int v = 0; v < 4; v++) begin
      longint s;
      longint na;
      bit w, hs;
      int saw, t7, trv, pls, sqv, n, sm, vo;
      s  = m_acc[v] + m_inc[v];
      w  = (s >= ACC_MOD);
      na = s % ACC_MOD;
      hs = 1'b0;
`ifdef OSC_HARD_SYNC_EN
      hs = (v > 0) ? (m_sync[v] && wr[v-1]) : 1'b0;
`endif
      if (hs) begin
        na = 0;
        w  = 1'b0;
      end else if (m_acc[v] < HALF && na >= HALF) begin
        m_sq[v] = !m_sq[v];
      end
      wr[v]    = w;
      m_acc[v] = na;
      saw = int'(na >> 8);
      t7  = int'((na >> 7) & FULL);
      trv = (na >= HALF) ? FULL - t7 : t7;
      pls = (saw < m_pw[v] * 64) ? FULL : 0;
      sqv = m_sq[v] ? FULL : 0;
      n = 0; sm = 0;
      if (m_sel[v] & 1) begin n++; sm += saw; end
      if (m_sel[v] & 2) begin n++; sm += trv; end
      if (m_sel[v] & 4) begin n++; sm += sqv; end
      if (m_sel[v] & 8) begin n++; sm += pls; end
      case (n)
        0:       vo = MID;
        1:       vo = sm;
        2:       vo = sm / 2;
        3:       vo = (sm / 4 + 2048) & FULL;
        default: vo = sm / 4;
      endcase
      total += vo;
    end
    return total / 4;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int v, input int a, input logic [15:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_voice = VB'(v);
    bus.cfg_addr  = 2'(a);
    bus.cfg_wdata = d;
    step();
    bus.cfg_we = 1'b0;
    case (a)
      0:       m_inc[v] = int'(d);
      1:       m_sel[v] = int'(d & 16'h000F);
      2:       m_pw[v]  = int'(d & 16'h00FF);
      default: m_sync[v] = d[0];
    endcase
  endtask

  // Waits (bounded) for out_valid, then pops the scoreboard and compares out.
  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (bus.out_valid && exp_q.size() > 0) begin
      check({name, " out"}, 32'(bus.out), exp_q.pop_front());
      check({name, " busy@valid"}, 32'(bus.busy), 1);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no out_valid within %0d cycles", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic tick_and_check(input int exp, input string name);
    int lat;
    exp_q.push_back(exp);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check({name, " busy@t+1"}, 32'(bus.busy), 1);
    wait_valid(name, lat);
    check({name, " latency"}, lat, VOICES + 1);
    step();
    check({name, " valid pulse"}, 32'(bus.out_valid), 0);
    check({name, " busy clear"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int lat;
    int nvalid;
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_voice   = '0;
    bus.cfg_addr    = '0;
    bus.cfg_wdata   = '0;

    vecs[0] = '{16'h0100, 16'hFFF1, 16'hFF10, 6143};
    vecs[1] = '{16'h8000, 16'h0002, 16'h0010, 6207};
    vecs[2] = '{16'h4000, 16'h0008, 16'h0010, 10239};
    vecs[3] = '{16'h4000, 16'h0008, 16'h0000, 6143};
    vecs[4] = '{16'h4000, 16'h0008, 16'h0001, 6143};
    vecs[5] = '{16'h4000, 16'h0008, 16'h0002, 10239};
    vecs[6] = '{16'h8000, 16'h0003, 16'h0010, 6191};
    vecs[7] = '{16'h8000, 16'h0007, 16'h0010, 6679};
    vecs[8] = '{16'h4000, 16'h000F, 16'h00FF, 7179};
    vecs[9] = '{16'h1234, 16'h0000, 16'h0010, 8191};

    // Reset state after release.
    step(); step(); step();
    rst = 1'b0;
    model_reset();
    repeat (10) step();
    check("reset out", 32'(bus.out), MID);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset overrun", 32'(bus.overrun), 0);

    // Single-tick vectors on voice 0, other voices silent (midpoint).
    for (int i = 0; i < 10; i++) begin
      do_reset();
      cfg_write(0, 0, vecs[i].inc);
      cfg_write(0, 1, vecs[i].sel);
      cfg_write(0, 2, vecs[i].pw);
      tick_and_check(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Config write mid-sweep reaches a voice processed later in the sweep.
    do_reset();
    cfg_write(3, 0, 16'h4000);
    exp_q.push_back(6159);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_voice = 2'd3; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'h0001;
    step();
    bus.cfg_we = 1'b0;
    wait_valid("midsweep cfg", lat);
    step();

    // Tick while busy: overrun pulse, single sweep.
    do_reset();
    cfg_write(0, 0, 16'h4000);
    cfg_write(0, 1, 16'h0001);
    exp_q.push_back(6159);
    bus.sample_tick = 1'b1; step();
    bus.sample_tick = 1'b0;
    check("overrun t+1", 32'(bus.overrun), 0);
    step();
    bus.sample_tick = 1'b1; step();
    bus.sample_tick = 1'b0;
    check("overrun t+3", 32'(bus.overrun), 1);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) check("overrun t+4", 32'(bus.overrun), 0);
      if (bus.out_valid) begin
        nvalid++;
        if (exp_q.size() > 0) check("overrun out", 32'(bus.out), exp_q.pop_front());
      end
    end
    check("overrun valid count", nvalid, 1);
    tick_and_check(6175, "after overrun");

    // Reset mid-sweep aborts with no out_valid.
    bus.sample_tick = 1'b1; step();
    bus.sample_tick = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0;
    model_reset();
    check("abort busy", 32'(bus.busy), 0);
    check("abort out", 32'(bus.out), MID);
    check("abort out_valid", 32'(bus.out_valid), 0);
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.out_valid) nvalid++;
    end
    check("abort no valid", nvalid, 0);
    tick_and_check(MID, "post-abort cfg cleared");
    cfg_write(0, 1, 16'h0001);
    tick_and_check(6143, "post-abort acc cleared");

    // Sub-octave square: flips on tick 33, not on the wrap at tick 65.
    do_reset();
    cfg_write(0, 0, 16'hFFFF);
    cfg_write(0, 1, 16'h0004);
    for (int k = 1; k <= 66; k++) begin
      tick_and_check(model_sweep(), $sformatf("sq tick%0d", k));
      if (k == 32) check("sq before flip", 32'(bus.out), 6143);
      if (k == 33) check("sq flip", 32'(bus.out), 10239);
      if (k == 65) check("sq hold at wrap", 32'(bus.out), 10239);
      step(); step();
    end

    // Hard sync of voice 1 to voice 0 wrap (ignored when the feature is absent).
    do_reset();
    cfg_write(0, 0, 16'hFFFF);
    cfg_write(1, 0, 16'h0010);
    cfg_write(1, 1, 16'h0001);
    cfg_write(1, 3, 16'h0001);
    for (int k = 1; k <= 66; k++) begin
      tick_and_check(model_sweep(), $sformatf("sync tick%0d", k));
      if (k == 64) check("sync tick64", 32'(bus.out), 6144);
      if (k == 65) check("sync tick65", 32'(bus.out), SYNC_EXP);
      step(); step();
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
